hazard_forward_unit: RTL and testbench
======================================

Name: hazard_forward_unit

Overview:
Hazard and forwarding controller for the 5-stage pipeline. Consumes the outputs of the ID/EX latch (MemRead, rs/rt fields) together with IF/ID, EX/MEM and MEM/WB destination information. It drives the write-enable, bubble and flush controls back into the PC, IF/ID, ID/EX and EX/MEM, and the EX-stage operand forwarding selects. Stall and flush events are counted for debug.

Parameters:
CNT_W, 16, width of the saturating event counters stall_count and flush_count

Ports:
clk  in  1  pipeline clock; all state updates on posedge
reset  in  1  synchronous, active-high
id_rs  in  5  IF/ID instruction[25:21]
id_rt  in  5  IF/ID instruction[20:16]
id_uses_rt  in  1  ID instruction reads rt as a source (R-type, beq, sw)
ex_memread  in  1  ID/EX MemRead output
ex_rs  in  5  ID/EX rs field output
ex_rt  in  5  ID/EX rt field output
mem_regwrite  in  1  EX/MEM RegWrite
mem_rd  in  5  EX/MEM destination register
wb_regwrite  in  1  MEM/WB RegWrite
wb_rd  in  5  MEM/WB destination register
branch_taken  in  1  branch resolved taken in MEM this cycle
pc_write  out  1  PC load enable
ifid_write  out  1  IF/ID load enable
idex_bubble  out  1  zero all ID/EX control inputs this cycle
ifid_flush  out  1  IF/ID loads a NOP
idex_flush  out  1  ID/EX loads a NOP
exmem_flush  out  1  EX/MEM loads a NOP
fwd_a  out  2  ALU operand A select: 00 regfile, 10 EX/MEM, 01 MEM/WB
fwd_b  out  2  ALU operand B select, same encoding as fwd_a
state  out  1  FSM state: 0 RUN, 1 STALL
stall_count  out  CNT_W  number of load-use stall events, saturating
flush_count  out  CNT_W  number of branch flush events, saturating

Behaviour:
- All hazard and forward outputs are combinational from current inputs, the FSM state and reset. Zero latency: a hazard seen in cycle N is acted on in cycle N.
- Load-use condition (lu):
  - ex_memread=1 and ex_rt!=0, and
  - ex_rt==id_rs, or (id_uses_rt=1 and ex_rt==id_rt).
- Stall is lu and not branch_taken and state==RUN. While stall is active: pc_write=0, ifid_write=0, idex_bubble=1.
- Flush is branch_taken. While flush is active: ifid_flush=idex_flush=exmem_flush=1, pc_write=1, ifid_write=1, idex_bubble=0.
- branch_taken has priority over lu in the same cycle. The wrong-path instruction is discarded, not held.
- Default with no stall and no flush: pc_write=1, ifid_write=1, all bubble and flush outputs 0.
- FSM:
  - RUN->STALL on posedge when stall is asserted.
  - STALL->RUN unconditionally on the next posedge.
  - In STALL, lu is ignored, which guarantees exactly one bubble per load-use. A stall that is already in progress does not block a flush.
- Forwarding for fwd_a, evaluated on ex_rs:
  - 10 if mem_regwrite=1, mem_rd!=0 and mem_rd==ex_rs;
  - else 01 if wb_regwrite=1, wb_rd!=0 and wb_rd==ex_rs;
  - else 00.
  - EX/MEM has priority over MEM/WB.
- fwd_b follows the same rules evaluated on ex_rt.
- Register 0 is never forwarded and never causes a stall.
- Counters:
  - stall_count increments by 1 on each posedge where stall=1.
  - flush_count increments by 1 on each posedge where flush=1.
  - Each counter saturates at 2^CNT_W-1 and never wraps.
- Reset, applied at any time including mid-stall:
  - On posedge with reset=1: state=RUN, stall_count=0, flush_count=0.
  - While reset=1, combinational outputs are forced: pc_write=1, ifid_write=1, idex_bubble=0, all flushes 0, fwd_a=fwd_b=00.
  - Counters do not increment while reset is high.

Test Plan:
- lw $8 in EX (ex_memread=1, ex_rt=8) and add with id_rs=8 in ID -> cycle N: pc_write=0, ifid_write=0, idex_bubble=1; cycle N+1: state=1, outputs return to defaults; stall_count=1.
- Same lw with id_rt=8 and id_uses_rt=0 -> no stall; with ex_rt=0 and id_rs=0 -> no stall.
- branch_taken=1 coincident with the load-use condition -> all three flushes=1, pc_write=1, idex_bubble=0; flush_count=1, stall_count unchanged, state stays RUN.
- mem_rd=5 with mem_regwrite=1, and wb_rd=5 with wb_regwrite=1, ex_rs=5 -> fwd_a=10. With mem_regwrite=0 -> fwd_a=01. With wb_rd=mem_rd=0 and ex_rt=0 -> fwd_b=00.
- CNT_W=2 and 5 load-use events -> stall_count goes 1,2,3,3,3 with no wrap.
- Assert reset in the cycle the FSM is in STALL -> next cycle state=0 and both counters=0; pc_write=1 and fwd_a=00 while reset is high, even if lu and forward conditions are present.

Source files
------------

// File: rtl/hazard_forward_if.sv
// Pipeline-side bundle for the hazard/forwarding controller: stage fields in,
// PC/latch controls, forward selects and debug counters out.
interface hazard_forward_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rt;
  logic             ex_memread;
  logic [4:0]       ex_rs;
  logic [4:0]       ex_rt;
  logic             mem_regwrite;
  logic [4:0]       mem_rd;
  logic             wb_regwrite;
  logic [4:0]       wb_rd;
  logic             branch_taken;

  logic             pc_write;
  logic             ifid_write;
  logic             idex_bubble;
  logic             ifid_flush;
  logic             idex_flush;
  logic             exmem_flush;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic             state;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output id_rs, id_rt, id_uses_rt, ex_memread, ex_rs, ex_rt,
           mem_regwrite, mem_rd, wb_regwrite, wb_rd, branch_taken,
    input  pc_write, ifid_write, idex_bubble, ifid_flush, idex_flush,
           exmem_flush, fwd_a, fwd_b, state, stall_count, flush_count
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, ex_memread, ex_rs, ex_rt,
           mem_regwrite, mem_rd, wb_regwrite, wb_rd, branch_taken,
    output pc_write, ifid_write, idex_bubble, ifid_flush, idex_flush,
           exmem_flush, fwd_a, fwd_b, state, stall_count, flush_count
  );
endinterface

// File: rtl/hazard_forward_unit.sv
// Load-use stall / branch flush controller with EX operand forwarding.
// Controls are combinational (zero latency); only the one-bubble FSM and counters are registered.

// One EX operand forwarding selector: EX/MEM beats MEM/WB, r0 never forwarded.
module hazard_fwd_sel (
  input  logic       reset,
  input  logic [4:0] src,
  input  logic       mem_regwrite,
  input  logic [4:0] mem_rd,
  input  logic       wb_regwrite,
  input  logic [4:0] wb_rd,
  output logic [1:0] sel
);
  always_comb begin
    sel = 2'b00;
    if (!reset) begin
      if (mem_regwrite && (mem_rd != 5'd0) && (mem_rd == src))
        sel = 2'b10;
      else if (wb_regwrite && (wb_rd != 5'd0) && (wb_rd == src))
        sel = 2'b01;
    end
  end
endmodule

module hazard_forward_unit #(
  parameter int CNT_W = 16
) (
  input logic             clk,
  input logic             reset,
  hazard_forward_if.slave hif
);
  localparam int         NUM_OPS = 2;
  localparam logic [0:0] RUN     = 1'b0;
  localparam logic [0:0] STALL   = 1'b1;

  logic [0:0]                   state_q;
  logic [CNT_W-1:0]             stall_cnt_q;
  logic [CNT_W-1:0]             flush_cnt_q;
  logic                         lu;
  logic                         stall;
  logic                         flush;
  logic [NUM_OPS-1:0][4:0]      op_src;
  logic [NUM_OPS-1:0][1:0]      op_sel;

  // Load-use: r0 as a load target never creates a dependency.
  always_comb begin
    lu = hif.ex_memread && (hif.ex_rt != 5'd0) &&
         ((hif.ex_rt == hif.id_rs) ||
          (hif.id_uses_rt && (hif.ex_rt == hif.id_rt)));
  end

  // Branch wins over the load-use; in STALL the bubble is already in flight.
  always_comb begin
    flush = !reset && hif.branch_taken;
    stall = !reset && lu && !hif.branch_taken && (state_q == RUN);
  end

  always_comb begin
    hif.pc_write    = !stall;
    hif.ifid_write  = !stall;
    hif.idex_bubble = stall;
    hif.ifid_flush  = flush;
    hif.idex_flush  = flush;
    hif.exmem_flush = flush;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
    end else begin
      case (state_q)
        RUN:     state_q <= stall ? STALL : RUN;
        STALL:   state_q <= RUN;
        default: state_q <= RUN;
      endcase
    end
  end

  // Saturating event counters; stall/flush are already masked by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall && (stall_cnt_q != {CNT_W{1'b1}}))
        stall_cnt_q <= stall_cnt_q + 1'b1;
      if (flush && (flush_cnt_q != {CNT_W{1'b1}}))
        flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign op_src[0] = hif.ex_rs;
  assign op_src[1] = hif.ex_rt;

  generate
    for (genvar i = 0; i < NUM_OPS; i++) begin : g_fwd
      hazard_fwd_sel u_sel (
        .reset        (reset),
        .src          (op_src[i]),
        .mem_regwrite (hif.mem_regwrite),
        .mem_rd       (hif.mem_rd),
        .wb_regwrite  (hif.wb_regwrite),
        .wb_rd        (hif.wb_rd),
        .sel          (op_sel[i])
      );
    end
  endgenerate

  assign hif.fwd_a       = op_sel[0];
  assign hif.fwd_b       = op_sel[1];
  assign hif.state       = state_q[0];
  assign hif.stall_count = stall_cnt_q;
  assign hif.flush_count = flush_cnt_q;
endmodule

// File: tb/tb_hazard_forward_unit.sv
// Bench: directed cases with literal expectations plus random traffic, all
// compared every cycle against a rule-level model of stalls, flushes and forwarding.
module tb_hazard_forward_unit;
  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  hazard_forward_if #(.CNT_W(16)) hif ();
  hazard_forward_if #(.CNT_W(2))  hif2 ();

  hazard_forward_unit #(.CNT_W(16)) dut  (.clk(clk), .reset(reset), .hif(hif));
  hazard_forward_unit #(.CNT_W(2))  dut2 (.clk(clk), .reset(reset), .hif(hif2));

  // model: did the previous cycle insert the bubble, plus integer event counts
  bit m_stalled;
  int m_sc, m_fc, m_sc2;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [4:0] irs, input logic [4:0] irt, input logic iurt,
                       input logic emr, input logic [4:0] ers, input logic [4:0] ert,
                       input logic mw, input logic [4:0] mrd,
                       input logic ww, input logic [4:0] wrd,
                       input logic bt, input logic rst);
    reset = rst;
    hif.id_rs = irs;   hif2.id_rs = irs;
    hif.id_rt = irt;   hif2.id_rt = irt;
    hif.id_uses_rt = iurt;   hif2.id_uses_rt = iurt;
    hif.ex_memread = emr;    hif2.ex_memread = emr;
    hif.ex_rs = ers;   hif2.ex_rs = ers;
    hif.ex_rt = ert;   hif2.ex_rt = ert;
    hif.mem_regwrite = mw;   hif2.mem_regwrite = mw;
    hif.mem_rd = mrd;  hif2.mem_rd = mrd;
    hif.wb_regwrite = ww;    hif2.wb_regwrite = ww;
    hif.wb_rd = wrd;   hif2.wb_rd = wrd;
    hif.branch_taken = bt;   hif2.branch_taken = bt;
  endtask

  function automatic logic [1:0] m_fwd(input logic [4:0] r);
    if (reset) return 2'b00;
    if (hif.mem_regwrite && hif.mem_rd != 0 && hif.mem_rd == r) return 2'b10;
    if (hif.wb_regwrite && hif.wb_rd != 0 && hif.wb_rd == r) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit m_stall();
    bit dep;
    dep = hif.ex_memread && hif.ex_rt != 0 &&
          (hif.ex_rt == hif.id_rs || (hif.id_uses_rt && hif.ex_rt == hif.id_rt));
    return !reset && dep && !hif.branch_taken && !m_stalled;
  endfunction

  task automatic compare_all();
    bit st, fl;
    st = m_stall();
    fl = !reset && hif.branch_taken;
    chk("pc_write", hif.pc_write, !st);
    chk("ifid_write", hif.ifid_write, !st);
    chk("idex_bubble", hif.idex_bubble, st);
    chk("ifid_flush", hif.ifid_flush, fl);
    chk("idex_flush", hif.idex_flush, fl);
    chk("exmem_flush", hif.exmem_flush, fl);
    chk("fwd_a", hif.fwd_a, m_fwd(hif.ex_rs));
    chk("fwd_b", hif.fwd_b, m_fwd(hif.ex_rt));
    chk("state", hif.state, m_stalled);
    chk("stall_count", hif.stall_count, m_sc);
    chk("flush_count", hif.flush_count, m_fc);
    chk("stall_count_w2", hif2.stall_count, m_sc2);
    chk("pc_write_w2", hif2.pc_write, !st);
  endtask

  task automatic update_model();
    bit st, fl;
    st = m_stall();
    fl = !reset && hif.branch_taken;
    if (reset) begin
      m_stalled = 0; m_sc = 0; m_fc = 0; m_sc2 = 0;
    end else begin
      m_stalled = st;
      if (st) begin
        m_sc  = (m_sc < 65535) ? m_sc + 1 : m_sc;
        m_sc2 = (m_sc2 < 3) ? m_sc2 + 1 : m_sc2;
      end
      if (fl) m_fc = (m_fc < 65535) ? m_fc + 1 : m_fc;
    end
  endtask

  // Compare at negedge, advance the model with the same inputs the posedge sees.
  task automatic cycle();
    @(negedge clk);
    compare_all();
    update_model();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic rst);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, rst);
  endtask

  int exp_sat[5] = '{1, 2, 3, 3, 3};

  initial begin
    m_stalled = 0; m_sc = 0; m_fc = 0; m_sc2 = 0;
    idle(1);
    @(posedge clk); #1;
    cycle();
    cycle();
    idle(0);
    #1;
    chk("rst_state", hif.state, 1'b0);
    chk("rst_stall_count", hif.stall_count, 16'd0);
    chk("rst_flush_count", hif.flush_count, 16'd0);
    cycle();

    // lw $8 in EX, consumer reads $8 as rs
    drive(8, 0, 0, 1, 0, 8, 0, 0, 0, 0, 0, 0);
    #1;
    chk("lu_pc_write", hif.pc_write, 1'b0);
    chk("lu_ifid_write", hif.ifid_write, 1'b0);
    chk("lu_bubble", hif.idex_bubble, 1'b1);
    cycle();
    #1;
    chk("lu_n1_state", hif.state, 1'b1);
    chk("lu_n1_pc_write", hif.pc_write, 1'b1);
    chk("lu_n1_bubble", hif.idex_bubble, 1'b0);
    chk("lu_n1_stall_count", hif.stall_count, 16'd1);
    cycle();

    // rt match without rt use, and r0 load target: no stall
    drive(0, 8, 0, 1, 0, 8, 0, 0, 0, 0, 0, 0);
    #1;
    chk("no_use_rt_pc_write", hif.pc_write, 1'b1);
    cycle();
    drive(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("r0_bubble", hif.idex_bubble, 1'b0);
    cycle();

    // branch coincident with load-use
    drive(8, 0, 0, 1, 0, 8, 0, 0, 0, 0, 1, 0);
    #1;
    chk("br_ifid_flush", hif.ifid_flush, 1'b1);
    chk("br_idex_flush", hif.idex_flush, 1'b1);
    chk("br_exmem_flush", hif.exmem_flush, 1'b1);
    chk("br_pc_write", hif.pc_write, 1'b1);
    chk("br_bubble", hif.idex_bubble, 1'b0);
    cycle();
    idle(0);
    #1;
    chk("br_flush_count", hif.flush_count, 16'd1);
    chk("br_stall_count", hif.stall_count, 16'd1);
    chk("br_state", hif.state, 1'b0);
    cycle();

    // forwarding priority and r0
    drive(0, 0, 0, 0, 5, 0, 1, 5, 1, 5, 0, 0);
    #1;
    chk("fwd_a_mem", hif.fwd_a, 2'b10);
    drive(0, 0, 0, 0, 5, 0, 0, 5, 1, 5, 0, 0);
    #1;
    chk("fwd_a_wb", hif.fwd_a, 2'b01);
    drive(0, 0, 0, 0, 5, 0, 1, 0, 1, 0, 0, 0);
    #1;
    chk("fwd_b_r0", hif.fwd_b, 2'b00);
    cycle();

    // 2-bit counter saturation
    idle(1);
    cycle();
    for (int i = 0; i < 5; i++) begin
      drive(8, 0, 0, 1, 0, 8, 0, 0, 0, 0, 0, 0);
      cycle();
      idle(0);
      #1;
      chk("sat_stall_count_w2", hif2.stall_count, exp_sat[i]);
      cycle();
    end

    // reset while in STALL, with lu and forward conditions present
    drive(8, 0, 0, 1, 8, 8, 0, 0, 0, 0, 0, 0);
    cycle();
    drive(8, 0, 0, 1, 8, 8, 1, 8, 0, 0, 0, 1);
    #1;
    chk("rst_stall_in_state", hif.state, 1'b1);
    chk("rst_hi_pc_write", hif.pc_write, 1'b1);
    chk("rst_hi_fwd_a", hif.fwd_a, 2'b00);
    cycle();
    idle(0);
    #1;
    chk("rst_lo_state", hif.state, 1'b0);
    chk("rst_lo_stall_count", hif.stall_count, 16'd0);
    chk("rst_lo_flush_count", hif.flush_count, 16'd0);
    cycle();

    // random traffic over a small register window to provoke matches
    for (int i = 0; i < 3000; i++) begin
      drive(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 1'($urandom),
            1'($urandom_range(0, 2) != 0), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            1'($urandom), 5'($urandom_range(0, 7)), 1'($urandom), 5'($urandom_range(0, 7)),
            1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 60) == 0));
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
